// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, function fields,
// FSM state numbering, ALU operation codes and datapath mux selects.
package controle_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_REM  = 3'b110;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_MUL  = 5'd8,
    ALU_MULH = 5'd9,
    ALU_DIV  = 5'd10,
    ALU_REM  = 5'd11
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_EXEC_M = 4'd13,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] orig_pc;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       illegal;
  } ctrl_t;

  // Branch outcome from the SUB flags; unknown funct3 values simply fall through.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic less);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = less;
      F3_BGE:  taken = !less;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/controle_multiciclo_alu_dec.sv
// Combinational ALU operation decoder: {opcode, funct3, funct7} -> ALU op code.
module controle_alu_dec
  import controle_pkg::*;
#(
  parameter int ALUCTRL_W = 5
) (
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  output logic [ALUCTRL_W-1:0] alu_op
);

  alu_op_t op;

  always_comb begin
    op = ALU_ADD;
    if (opcode == OP_R && funct7 == F7_MULDIV) begin
      case (funct3)
        F3_MUL:  op = ALU_MUL;
        F3_MULH: op = ALU_MULH;
        F3_DIV:  op = ALU_DIV;
        F3_REM:  op = ALU_REM;
        default: op = ALU_ADD;
      endcase
    end else if (opcode == OP_R || opcode == OP_IMM) begin
      case (funct3)
        F3_ADD: begin
          // Only the register form has a SUB; addi's imm[11:5] is not a funct7.
          if (opcode == OP_R && funct7 == F7_ALT) op = ALU_SUB;
          else op = ALU_ADD;
        end
        F3_SLT:  op = ALU_SLT;
        F3_XOR:  op = ALU_XOR;
        F3_OR:   op = ALU_OR;
        F3_AND:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end
  end

  assign alu_op = ALUCTRL_W'(op);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control FSM with memory wait-states, bus timeout and illegal-op flag.
// Define CTRL_RV32M_EN to route OP_R/funct7=0000001 through the EXEC_M state.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int ALUCTRL_W      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [31:0]          iInst,
  input  logic                 iMemReady,
  input  logic                 iZero,
  input  logic                 iLess,
  input  logic                 iMulDivDone,
  output logic                 oPCWrite,
  output logic [1:0]           oOrigPC,
  output logic                 oIorD,
  output logic                 oMemRead,
  output logic                 oMemWrite,
  output logic                 oIRWrite,
  output logic [1:0]           oMemtoReg,
  output logic                 oRegWrite,
  output logic [1:0]           oALUSrcA,
  output logic [1:0]           oALUSrcB,
  output logic [ALUCTRL_W-1:0] oALUControl,
  output logic [3:0]           oState,
  output logic                 oIllegal,
  output logic                 oBusErr
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state;
  state_t                next_state;
  state_t                dispatch;
  logic [15:0]           tmo_cnt;
  logic                  bus_err;
  logic                  illegal_op;
  logic                  waiting;
  logic                  timeout_hit;
  ctrl_t                 ctrl;
  ctrl_t                 ctrl_gated;
  logic [ALUCTRL_W-1:0]  alu_sel;
  logic [ALUCTRL_W-1:0]  alu_dec_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = iInst[6:0];
  assign funct3 = iInst[14:12];
  assign funct7 = iInst[31:25];

  logic unused_inst;
  assign unused_inst = ^{iInst[24:15], iInst[11:7]};

`ifndef CTRL_RV32M_EN
  logic unused_muldiv;
  assign unused_muldiv = iMulDivDone;
`endif

  controle_alu_dec #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .opcode(opcode),
    .funct3(funct3),
    .funct7(funct7),
    .alu_op(alu_dec_op)
  );

  always_comb begin
    dispatch   = S_FETCH;
    illegal_op = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: dispatch = S_MEMADR;
      OP_R: begin
        if (funct7 == F7_MULDIV) begin
`ifdef CTRL_RV32M_EN
          dispatch = S_EXEC_M;
`else
          illegal_op = 1'b1;
`endif
        end else begin
          dispatch = S_EXEC_R;
        end
      end
      OP_IMM:    dispatch = S_EXEC_I;
      OP_BRANCH: dispatch = S_BRANCH;
      OP_JAL:    dispatch = S_JAL;
      OP_JALR:   dispatch = S_JALR;
      OP_LUI:    dispatch = S_LUI;
      default:   illegal_op = 1'b1;
    endcase
  end

  // A ready arriving on the limit cycle completes the access instead of faulting.
  assign waiting     = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !iMemReady;
  assign timeout_hit = waiting && (tmo_cnt == TMO_LAST);

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  if (iMemReady) next_state = S_DECODE; else next_state = S_FETCH;
      S_DECODE: next_state = dispatch;
      S_MEMADR: if (opcode == OP_LOAD) next_state = S_MEMRD; else next_state = S_MEMWR;
      S_MEMRD:  if (iMemReady) next_state = S_MEMWB; else next_state = S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (iMemReady) next_state = S_FETCH; else next_state = S_MEMWR;
      S_EXEC_R: next_state = S_ALUWB;
      S_EXEC_I: next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
`ifdef CTRL_RV32M_EN
      S_EXEC_M: if (iMulDivDone) next_state = S_ALUWB; else next_state = S_EXEC_M;
`endif
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_FETCH;
    endcase
    if (timeout_hit) next_state = S_ERROR;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= S_FETCH;
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) tmo_cnt <= '0;
      else if (waiting) tmo_cnt <= tmo_cnt + 16'd1;
      if (timeout_hit) bus_err <= 1'b1;
    end
  end

  always_comb begin
    ctrl    = '0;
    alu_sel = ALUCTRL_W'(ALU_ADD);
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.orig_pc   = PC_ALU;
        ctrl.ir_write  = iMemReady;
        ctrl.pc_write  = iMemReady;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.illegal   = illegal_op;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_MDR;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        alu_sel        = alu_dec_op;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        alu_sel        = alu_dec_op;
      end
`ifdef CTRL_RV32M_EN
      S_EXEC_M: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        alu_sel        = alu_dec_op;
      end
`endif
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.orig_pc   = PC_ALUOUT;
        ctrl.pc_write  = branch_taken(funct3, iZero, iLess);
        alu_sel        = ALUCTRL_W'(ALU_SUB);
      end
      S_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.orig_pc    = PC_ALUOUT;
      end
      S_JALR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.orig_pc    = PC_JALR;
      end
      S_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_IMM;
      end
      default: ;
    endcase
  end

  // Everything is held quiet while reset is asserted, even though state already reads FETCH.
  assign ctrl_gated  = iRST ? ctrl : '0;
  assign oALUControl = iRST ? alu_sel : '0;

  assign oPCWrite  = ctrl_gated.pc_write;
  assign oOrigPC   = ctrl_gated.orig_pc;
  assign oIorD     = ctrl_gated.iord;
  assign oMemRead  = ctrl_gated.mem_read;
  assign oMemWrite = ctrl_gated.mem_write;
  assign oIRWrite  = ctrl_gated.ir_write;
  assign oMemtoReg = ctrl_gated.mem_to_reg;
  assign oRegWrite = ctrl_gated.reg_write;
  assign oALUSrcA  = ctrl_gated.alu_src_a;
  assign oALUSrcB  = ctrl_gated.alu_src_b;
  assign oIllegal  = ctrl_gated.illegal;
  assign oState    = state;
  assign oBusErr   = bus_err;

endmodule
